// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit
//  Description : Registered barrel shifter. Captures an operand, a shift
//                amount and a mode on a qualified clock edge, then presents
//                the left-shifted and right-shifted results together one
//                cycle later. Supports logical, arithmetic and rotate modes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        operand / result width in bits (legal range 2..64)
//    SHAMT_W      shift-amount width; wide enough to encode WIDTH itself
//
//  Ports
//    clk          in   1        rising-edge clock
//    rst_n        in   1        asynchronous active-low reset
//    in_valid     in   1        qualifies a / shamt / mode for capture
//    a            in   WIDTH    operand
//    shamt        in   SHAMT_W  shift amount
//    mode         in   2        00 logical, 01 arithmetic, 10 rotate,
//                               11 logical
//    out_valid    out  1        results updated this cycle
//    shift_left   out  WIDTH    registered left result
//    shift_right  out  WIDTH    registered right result
//    carry_left   out  1        last bit shifted out of the MSB side
//                               (only with SHIFT_UNIT_CARRY_EN)
//    carry_right  out  1        last bit shifted out of the LSB side
//                               (only with SHIFT_UNIT_CARRY_EN)
//
//  Build option
//    SHIFT_UNIT_CARRY_EN  define to add the carry_left / carry_right outputs
// ============================================================================

module shift_unit #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
`ifdef SHIFT_UNIT_CARRY_EN
    output logic               carry_left,
    output logic               carry_right,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   shift_left,
    output logic [WIDTH-1:0]   shift_right
);

    // ------------------------------------------------------------------------
    // Mode encodings. 2'b11 is deliberately not decoded and falls through to
    // the logical behaviour.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_MODE_LOGIC = 2'b00;
    localparam logic [1:0] c_MODE_ARITH = 2'b01;
    localparam logic [1:0] c_MODE_ROT   = 2'b10;

    // Number of operand copies used by the rotate network. SHAMT_W is
    // clog2(WIDTH)+1 bits, so shamt is always below 4*WIDTH; five copies
    // leave enough periodic headroom that a plain shift of the replicated
    // word yields rotate-by-(shamt mod WIDTH) without a modulo operator.
    localparam int c_ROT_COPIES = 5;
    localparam int c_ROT_W      = c_ROT_COPIES * WIDTH;

    // ------------------------------------------------------------------------
    // Combinational shift network
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   w_lsl;          // logical left (also arithmetic left)
    logic [WIDTH-1:0]   w_lsr;          // logical right
    logic [WIDTH-1:0]   w_asr;          // arithmetic right
    logic [c_ROT_W-1:0] w_rep;          // operand replicated for rotation
    logic [WIDTH-1:0]   w_rol;          // rotate left
    logic [WIDTH-1:0]   w_ror;          // rotate right
    logic [WIDTH-1:0]   w_res_left;
    logic [WIDTH-1:0]   w_res_right;

    // Shifts by an amount of WIDTH or more naturally produce zero (or full
    // sign fill for >>>), which is exactly the required saturation behaviour.
    assign w_lsl = a << shamt;
    assign w_lsr = a >> shamt;
    assign w_asr = $unsigned($signed(a) >>> shamt);

    // Rotate left: top WIDTH bits of the shifted replica.
    // Rotate right: bottom WIDTH bits of the shifted replica.
    assign w_rep = {c_ROT_COPIES{a}};
    assign w_rol = WIDTH'((w_rep << shamt) >> (4 * WIDTH));
    assign w_ror = WIDTH'(w_rep >> shamt);

    always_comb begin
        w_res_left  = w_lsl;
        w_res_right = w_lsr;
        case (mode)
            c_MODE_ARITH: begin
                w_res_left  = w_lsl;
                w_res_right = w_asr;
            end
            c_MODE_ROT: begin
                w_res_left  = w_rol;
                w_res_right = w_ror;
            end
            default: begin
                w_res_left  = w_lsl;
                w_res_right = w_lsr;
            end
        endcase
    end

`ifdef SHIFT_UNIT_CARRY_EN
    // ------------------------------------------------------------------------
    // Carry network
    // ------------------------------------------------------------------------
    logic w_cl_shift;                   // left carry, logical/arithmetic
    logic w_cr_logic;                   // right carry, logical
    logic w_cr_arith;                   // right carry, arithmetic
    logic w_cl_rot;                     // left carry, rotate
    logic w_cr_rot;                     // right carry, rotate
    logic w_shamt_nz;
    logic w_carry_left;
    logic w_carry_right;

    // A guard bit beyond the operand catches the last bit to fall off:
    // it is a[WIDTH-shamt] on the left and a[shamt-1] on the right, zero for
    // shamt=0, and zero (or the sign bit for >>>) once shamt exceeds WIDTH.
    assign w_cl_shift = 1'(({1'b0, a} << shamt) >> WIDTH);
    assign w_cr_logic = 1'({a, 1'b0} >> shamt);
    assign w_cr_arith = 1'($unsigned($signed({a, 1'b0}) >>> shamt));

    // The bit that wrapped last lands at the far end of the rotated result.
    assign w_shamt_nz = |shamt;
    assign w_cl_rot   = w_shamt_nz & w_rol[0];
    assign w_cr_rot   = w_shamt_nz & w_ror[WIDTH-1];

    always_comb begin
        w_carry_left  = w_cl_shift;
        w_carry_right = w_cr_logic;
        case (mode)
            c_MODE_ARITH: begin
                w_carry_left  = w_cl_shift;
                w_carry_right = w_cr_arith;
            end
            c_MODE_ROT: begin
                w_carry_left  = w_cl_rot;
                w_carry_right = w_cr_rot;
            end
            default: begin
                w_carry_left  = w_cl_shift;
                w_carry_right = w_cr_logic;
            end
        endcase
    end

    logic r_carry_left;
    logic r_carry_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_left  <= 1'b0;
            r_carry_right <= 1'b0;
        end else if (in_valid) begin
            r_carry_left  <= w_carry_left;
            r_carry_right <= w_carry_right;
        end
    end

    assign carry_left  = r_carry_left;
    assign carry_right = r_carry_right;
`endif

    // ------------------------------------------------------------------------
    // Result registers: results hold while in_valid is low, out_valid is a
    // single-cycle strobe per capture.
    // ------------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_shift_left;
    logic [WIDTH-1:0] r_shift_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_shift_left  <= '0;
            r_shift_right <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_shift_left  <= w_res_left;
                r_shift_right <= w_res_right;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign shift_left  = r_shift_left;
    assign shift_right = r_shift_right;

endmodule

`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit
//  Description : Self-checking bench for shift_unit (WIDTH=4). Directed
//                vector table plus hand-written reset and hold sequences.
//                Carry outputs are checked when SHIFT_UNIT_CARRY_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_unit;

    localparam int WIDTH   = 4;
    localparam int SHAMT_W = 3;
    localparam int N_VEC   = 20;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         mode;
    logic               out_valid;
    logic [WIDTH-1:0]   shift_left;
    logic [WIDTH-1:0]   shift_right;
`ifdef SHIFT_UNIT_CARRY_EN
    logic               carry_left;
    logic               carry_right;
`endif

    int n_applied = 0;
    int n_miscompares = 0;

    shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .shamt       (shamt),
        .mode        (mode),
`ifdef SHIFT_UNIT_CARRY_EN
        .carry_left  (carry_left),
        .carry_right (carry_right),
`endif
        .out_valid   (out_valid),
        .shift_left  (shift_left),
        .shift_right (shift_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         mode;
        logic [WIDTH-1:0]   exp_l;
        logic [WIDTH-1:0]   exp_r;
        logic               exp_cl;
        logic               exp_cr;
    } vec_t;

    vec_t vecs[N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [WIDTH-1:0] l,
                                 input logic [WIDTH-1:0] r, input logic cl, input logic cr);
        check({tag, ".out_valid"},   32'(out_valid),   32'(v));
        check({tag, ".shift_left"},  32'(shift_left),  32'(l));
        check({tag, ".shift_right"}, 32'(shift_right), 32'(r));
`ifdef SHIFT_UNIT_CARRY_EN
        check({tag, ".carry_left"},  32'(carry_left),  32'(cl));
        check({tag, ".carry_right"}, 32'(carry_right), 32'(cr));
`else
        if (cl === 1'bx || cr === 1'bx) $display("note: carry expectations unknown");
`endif
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] av,
                         input logic [SHAMT_W-1:0] sv, input logic [1:0] mv);
        @(negedge clk);
        in_valid = v;
        a        = av;
        shamt    = sv;
        mode     = mv;
    endtask

    initial begin
        //              a        shamt  mode   left     right    cl    cr
        vecs[0]  = '{4'd12,    3'd1, 2'b00, 4'd8,    4'd6,    1'b1, 1'b0};
        vecs[1]  = '{4'd3,     3'd1, 2'b00, 4'd6,    4'd1,    1'b0, 1'b1};
        vecs[2]  = '{4'd0,     3'd1, 2'b00, 4'd0,    4'd0,    1'b0, 1'b0};
        vecs[3]  = '{4'b1010,  3'd1, 2'b01, 4'b0100, 4'b1101, 1'b1, 1'b0};
        vecs[4]  = '{4'b1010,  3'd4, 2'b01, 4'b0000, 4'b1111, 1'b0, 1'b1};
        vecs[5]  = '{4'b1001,  3'd1, 2'b10, 4'b0011, 4'b1100, 1'b1, 1'b1};
        vecs[6]  = '{4'b1001,  3'd5, 2'b10, 4'b0011, 4'b1100, 1'b1, 1'b1};
        vecs[7]  = '{4'b1011,  3'd0, 2'b00, 4'b1011, 4'b1011, 1'b0, 1'b0};
        vecs[8]  = '{4'b0110,  3'd0, 2'b10, 4'b0110, 4'b0110, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000,  3'd0, 2'b01, 4'b1000, 4'b1000, 1'b0, 1'b0};
        vecs[10] = '{4'b1111,  3'd4, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[11] = '{4'b1111,  3'd6, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{4'b1001,  3'd7, 2'b01, 4'b0000, 4'b1111, 1'b0, 1'b1};
        vecs[13] = '{4'b0111,  3'd6, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{4'b1100,  3'd2, 2'b11, 4'b0000, 4'b0011, 1'b1, 1'b0};
        vecs[15] = '{4'b1011,  3'd2, 2'b10, 4'b1110, 4'b1110, 1'b0, 1'b1};
        vecs[16] = '{4'b1011,  3'd4, 2'b10, 4'b1011, 4'b1011, 1'b1, 1'b1};
        vecs[17] = '{4'b1101,  3'd3, 2'b00, 4'b1000, 4'b0001, 1'b0, 1'b1};
        vecs[18] = '{4'b1101,  3'd2, 2'b01, 4'b0100, 4'b1111, 1'b1, 1'b0};
        vecs[19] = '{4'b0110,  3'd1, 2'b01, 4'b1100, 4'b0011, 1'b0, 1'b0};

        // Reset state, asserted from time zero with a live capture request.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'b1111;
        shamt    = 3'd1;
        mode     = 2'b00;
        #1;
        check_outputs("reset_t0", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("reset_edge", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back to back.
        for (int i = 0; i < N_VEC; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].shamt, vecs[i].mode);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), 1'b1, vecs[i].exp_l, vecs[i].exp_r,
                          vecs[i].exp_cl, vecs[i].exp_cr);
        end

        // Hold: one capture, then three idle cycles with a moving operand.
        drive(1'b1, 4'd12, 3'd1, 2'b00);
        @(posedge clk); #1;
        check_outputs("hold_cap", 1'b1, 4'd8, 4'd6, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'(k + 5), 3'd2, 2'b10);
            @(posedge clk); #1;
            check_outputs($sformatf("hold%0d", k), 1'b0, 4'd8, 4'd6, 1'b1, 1'b0);
        end

        // Mid-run reset with in_valid held high.
        drive(1'b1, 4'b1111, 3'd1, 2'b00);
        @(posedge clk); #1;
        check_outputs("pre_rst", 1'b1, 4'b1110, 4'b0111, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("rst_async", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("rst_override", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a     = 4'd3;
        #1;
        check_outputs("rst_release", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("first_after_rst", 1'b1, 4'd6, 4'd1, 1'b0, 1'b1);

        drive(1'b0, 4'd0, 3'd0, 2'b00);
        @(posedge clk); #1;
        check_outputs("idle_after_rst", 1'b0, 4'd6, 4'd1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Registered barrel shifter: captures an operand and shift amount, then produces both left-shifted and right-shifted results one clock later.
- Default configuration (4-bit, shift by 1) is the basic operator block; used wherever a datapath needs simultaneous left/right shift results.
- Supports logical, arithmetic and rotate modes.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..64).
- SHAMT_W, $clog2(WIDTH)+1, width of the shift-amount input; wide enough to encode the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, shamt and mode for capture.
- a  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount; drive 1 for the basic shift-by-one operation.
- mode  input  2  00 logical, 01 arithmetic (right only), 10 rotate, 11 treated as logical.
- out_valid  output  1  results updated this cycle.
- shift_left  output  WIDTH  registered left result.
- shift_right  output  WIDTH  registered right result.

Behaviour:
- Reset:
  - rst_n low clears shift_left, shift_right and out_valid to 0 immediately, independent of clk.
  - First capture happens on the first rising edge after rst_n deasserts.
- Capture and latency:
  - On a rising edge with in_valid=1, both results are computed from a/shamt/mode and registered; out_valid=1 for that cycle.
  - Latency is exactly 1 cycle. Throughput is 1 operation per cycle; back-to-back in_valid is allowed.
- Hold: with in_valid=0, shift_left and shift_right hold their last values and out_valid=0.
- Logical mode:
  - shift_left = a << shamt, zero-filled.
  - shift_right = a >> shamt, zero-filled.
- Arithmetic mode:
  - shift_left is identical to logical mode.
  - shift_right fills with a[WIDTH-1].
- Rotate mode:
  - shift_left rotates left by shamt mod WIDTH.
  - shift_right rotates right by shamt mod WIDTH.
- Boundary conditions:
  - shamt=0: both outputs equal a in all modes.
  - shamt>=WIDTH, logical: both outputs are 0.
  - shamt>=WIDTH, arithmetic: shift_left=0; shift_right is all copies of a[WIDTH-1].
  - shamt>=WIDTH, rotate: amount is taken modulo WIDTH.
- Arithmetic rules:
  - Results are truncated to WIDTH; no widening.
  - Operands are unsigned except for the sign-fill in arithmetic mode.
- Reset during operation: an asserted rst_n overrides any capture in the same cycle; the pending result is discarded.

Optional Feature:
- Macro: SHIFT_UNIT_CARRY_EN.
- When defined, adds two registered outputs:
  - carry_left: last bit shifted out of the MSB side.
  - carry_right: last bit shifted out of the LSB side.
- Both carries follow the same latency, hold and reset (0) rules as the results.
- Carry values by case:
  - shamt=0: both carries are 0.
  - Rotate mode: each carry is the bit that wrapped last.
  - shamt>WIDTH, logical: 0.
  - shamt>WIDTH, arithmetic: carry_right equals a[WIDTH-1].
- When not defined, the ports and their logic do not exist.

Test Plan:
- Reset: hold rst_n=0 mid-run with in_valid=1 -> shift_left=0, shift_right=0, out_valid=0 immediately; first result appears 1 cycle after release.
- Basic logical, WIDTH=4, shamt=1, mode=00, one cycle after each capture:
  - a=4'd12 -> shift_left=4'b1000 (8), shift_right=4'b0110 (6).
  - a=4'd3 -> shift_left=4'b0110 (6), shift_right=4'b0001 (1).
  - a=4'd0 -> both 0.
- Hold: capture a=12, then in_valid=0 for 3 cycles with a changing -> outputs stay 8/6, out_valid=0.
- Arithmetic right: a=4'b1010, shamt=1, mode=01 -> shift_right=4'b1101, shift_left=4'b0100. With shamt=4 -> shift_right=4'b1111, shift_left=0.
- Rotate:
  - a=4'b1001, shamt=1, mode=10 -> shift_left=4'b0011, shift_right=4'b1100.
  - Same a with shamt=5 -> same results.
- Carry (SHIFT_UNIT_CARRY_EN): a=4'd12, shamt=1, mode=00 -> carry_left=1, carry_right=0. With a=4'd3 -> carry_left=0, carry_right=1.
